alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequencing front end for the single-cycle ALU: accepts one instruction word per valid/ready handshake, decodes it, fetches operands from the register file, drives the ALU opcode/operand/shift-amount inputs, captures result and overflow, and issues the register-file writeback. Overflow on add/addi/sub is redirected to $r30 ($rstatus) with a code. The block sits between instruction fetch and the regfile/ALU pair, and is the initiator side of the ALU interface.

## Interface
- No parameters. Data width is 32 and register index width is 5, both fixed.
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- inst_valid  in  1  instruction word offered
- inst  in  32  instruction word
- inst_ready  out  1  block is idle and can accept `inst`
- ctrl_readRegA / ctrl_readRegB  out  5  regfile read addresses; regfile read is combinational
- data_readRegA / data_readRegB  in  32  regfile read data
- alu_opA / alu_opB  out  32  ALU operands
- alu_opcode / alu_shamt  out  5  ALU opcode and shift amount
- alu_result  in  32  ALU result
- alu_overflow  in  1  ALU overflow flag
- ctrl_writeEnable  out  1  one-cycle regfile write strobe
- ctrl_writeReg  out  5  write address
- data_writeReg  out  32  write data
- err_illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- Instruction fields: opcode [31:27]; rd [26:22]; rs [21:17]; rt [16:12]; shamt [11:7]; aluop [6:2]; imm [16:0], sign-extended to 32 bits.
- Supported instructions:
  - opcode 00000 (R-type), aluop 0–5 = add, sub, and, or, sll, sra. Operands are rs and rt. sll/sra use shamt.
  - opcode 00101 (addi): operands rs and sext(imm); ALU opcode forced to add; shamt is 0.
  - Anything else, including R-type aluop > 5, is illegal.
- FSM states, one cycle each except IDLE:
  - IDLE: inst_ready=1. On inst_valid&inst_ready, latch inst and go to READ.
  - READ: drive ctrl_readRegA=rs and ctrl_readRegB=rt. Capture data_readRegA/B, or the immediate, into operand registers. Go to EXEC.
  - EXEC: drive alu_* from the operand registers. Capture alu_result and alu_overflow. Go to WB.
  - WB: registered writeback outputs are valid for exactly this cycle. Return to IDLE.
- Writeback rules, applied in WB:
  - overflow on add: write $r30 = 1.
  - overflow on addi: write $r30 = 2.
  - overflow on sub: write $r30 = 3. On overflow, rd is not written.
  - Overflow is ignored for and, or, sll and sra.
  - rd = 0 with no overflow: ctrl_writeEnable stays 0.
  - Illegal instruction: no write; err_illegal=1 for the WB cycle.
- Outside WB: ctrl_writeEnable=0, err_illegal=0, ctrl_writeReg=0, data_writeReg=0.
- Outside EXEC, alu_* outputs are 0.
- ctrl_readRegA/B are 0 outside READ.
- Only one instruction is in flight at a time, so there are no data hazards. A write lands before the next READ.

## Timing
- Reset (asserted, asynchronous): state goes to IDLE. All registered outputs and internal registers go to 0.
  - inst_ready equals (state==IDLE), so it reads 1 while reset is low. No handshake is taken while reset is low.
- Latency: accept at edge T; READ is cycle T+1, EXEC T+2, WB T+3. inst_ready returns at T+4.
- Throughput: one instruction per 4 cycles.
- Handshake: the word is consumed on the rising edge where inst_valid&inst_ready=1.
  - An inst_valid held during READ/EXEC/WB is not consumed.
  - The upstream stage holds inst stable until it is accepted.
- Reset mid-operation (any state): the in-flight instruction is discarded, no write occurs, and the block is in IDLE after reset release.
- Arithmetic is 32-bit two's complement. The immediate is sign-extended from bit 16.

## Structure
- Shared package `alu_issue_pkg`:
  - ALU opcode constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLL=4, ALU_SRA=5.
  - Instruction opcode constants OP_RTYPE=5'b00000, OP_ADDI=5'b00101.
  - $rstatus codes 1/2/3 and RSTATUS_REG=30.
  - 2-bit FSM state encoding IDLE/READ/EXEC/WB.
- One sub-module, `alu_inst_decode` (combinational). Input: the latched instruction. Outputs: field slices, sign-extended immediate, effective ALU opcode, use_imm, illegal, and the overflow code for the instruction.
- The top level contains the FSM, operand/result registers and writeback mux.

## Test plan
- add r3,r1,r2 with r1=5, r2=7 -> in the WB cycle (T+3): ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=12; inst_ready high at T+4.
- addi r4,r1,imm=0x1FFFF with r1=0 -> write r4=0xFFFFFFFF.
- Overflow cases, each with no write to rd:
  - add with 0x7FFFFFFF+1 -> write r30=1.
  - sub with 0x80000000−1 -> write r30=3.
  - addi with 0x7FFFFFFF+1 -> write r30=2.
- Shifts:
  - sll r5,r1 shamt=4 with r1=3 -> r5=48.
  - sra with r1=0x80000000, shamt=31 -> 0xFFFFFFFF.
- Suppressed writes:
  - add r0,r1,r2 -> ctrl_writeEnable stays 0.
  - opcode 11111 -> err_illegal pulses 1 cycle in WB, no write.
  - R-type aluop=6 -> err_illegal pulses 1 cycle in WB, no write.
- Handshake and reset:
  - inst_valid held high for 10 cycles with two back-to-back words -> accepted 4 cycles apart.
  - reset asserted during EXEC -> all outputs 0 immediately, no WB.
  - After release, the next add completes with 4-cycle latency.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue front end: ALU/instruction opcodes,
// $rstatus overflow codes and the issue FSM state encoding.
package alu_issue_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;

    // Overflow codes written to $rstatus; OVF_NONE marks ops whose overflow is ignored.
    localparam logic [1:0] OVF_NONE     = 2'd0;
    localparam logic [1:0] RSTATUS_ADD  = 2'd1;
    localparam logic [1:0] RSTATUS_ADDI = 2'd2;
    localparam logic [1:0] RSTATUS_SUB  = 2'd3;
    localparam logic [4:0] RSTATUS_REG  = 5'd30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [16:0] imm);
        return {{(DATA_W-17){imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/alu_inst_decode.sv
// Combinational decode of a latched instruction word into register fields,
// immediate, effective ALU opcode and overflow handling class.
module alu_inst_decode
    import alu_issue_pkg::*;
(
    input  logic                     [DATA_W-1:0] inst,
    output logic                     [REG_W-1:0]  rd,
    output logic                     [REG_W-1:0]  rs,
    output logic                     [REG_W-1:0]  rt,
    output logic                     [4:0]        shamt,
    output logic signed              [DATA_W-1:0] imm,
    output logic                     [4:0]        alu_op,
    output logic                                  use_imm,
    output logic                                  illegal,
    output logic                     [1:0]        ovf_code
);

    logic [4:0] opcode;
    logic [4:0] aluop_f;
    logic       unused_bits;

    assign opcode      = inst[31:27];
    assign aluop_f     = inst[6:2];
    assign rd          = inst[26:22];
    assign rs          = inst[21:17];
    assign rt          = inst[16:12];
    assign imm         = sext_imm(inst[16:0]);
    assign unused_bits = ^inst[1:0];

    always_comb begin
        alu_op   = ALU_ADD;
        shamt    = '0;
        use_imm  = 1'b0;
        illegal  = 1'b0;
        ovf_code = OVF_NONE;
        case (opcode)
            OP_RTYPE: begin
                if (aluop_f <= ALU_SRA) begin
                    alu_op = aluop_f;
                    if (aluop_f == ALU_SLL || aluop_f == ALU_SRA)
                        shamt = inst[11:7];
                    if (aluop_f == ALU_ADD)
                        ovf_code = RSTATUS_ADD;
                    else if (aluop_f == ALU_SUB)
                        ovf_code = RSTATUS_SUB;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDI: begin
                use_imm  = 1'b1;
                ovf_code = RSTATUS_ADDI;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer: accept one instruction, read operands, drive the ALU for one cycle,
// then present a one-cycle registered regfile writeback (or $rstatus overflow code).
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] inst,
    output logic              inst_ready,
    output logic [REG_W-1:0]  ctrl_readRegA,
    output logic [REG_W-1:0]  ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    output logic [DATA_W-1:0] alu_opA,
    output logic [DATA_W-1:0] alu_opB,
    output logic [4:0]        alu_opcode,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              err_illegal
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [4:0]          opcode_q, opcode_d;
    logic [4:0]          shamt_q, shamt_d;
    logic                we_q, we_d;
    logic [REG_W-1:0]    wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    logic [REG_W-1:0]    dec_rd, dec_rs, dec_rt;
    logic [4:0]          dec_shamt, dec_alu_op;
    logic signed [DATA_W-1:0] dec_imm;
    logic                dec_use_imm, dec_illegal;
    logic [1:0]          dec_ovf_code;

    alu_inst_decode u_decode (
        .inst     (inst_q),
        .rd       (dec_rd),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .shamt    (dec_shamt),
        .imm      (dec_imm),
        .alu_op   (dec_alu_op),
        .use_imm  (dec_use_imm),
        .illegal  (dec_illegal),
        .ovf_code (dec_ovf_code)
    );

    // Operand, ALU and writeback registers default to zero so each is live for exactly one state.
    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        op_a_d   = '0;
        op_b_d   = '0;
        opcode_d = '0;
        shamt_d  = '0;
        we_d     = 1'b0;
        wreg_d   = '0;
        wdata_d  = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    inst_d  = inst;
                    state_d = READ;
                end
            end
            READ: begin
                op_a_d   = data_readRegA;
                op_b_d   = dec_use_imm ? $unsigned(dec_imm) : data_readRegB;
                opcode_d = dec_alu_op;
                shamt_d  = dec_shamt;
                state_d  = EXEC;
            end
            EXEC: begin
                state_d = WB;
                if (dec_illegal) begin
                    err_d = 1'b1;
                end else if (alu_overflow && dec_ovf_code != OVF_NONE) begin
                    we_d    = 1'b1;
                    wreg_d  = RSTATUS_REG;
                    wdata_d = {{(DATA_W-2){1'b0}}, dec_ovf_code};
                end else if (dec_rd != '0) begin
                    we_d    = 1'b1;
                    wreg_d  = dec_rd;
                    wdata_d = alu_result;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            inst_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            shamt_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            shamt_q  <= shamt_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    assign inst_ready       = (state_q == IDLE);
    assign ctrl_readRegA    = (state_q == READ) ? dec_rs : '0;
    assign ctrl_readRegB    = (state_q == READ) ? dec_rt : '0;
    assign alu_opA          = op_a_q;
    assign alu_opB          = op_b_q;
    assign alu_opcode       = opcode_q;
    assign alu_shamt        = shamt_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign err_illegal      = err_q;

endmodule
